// File: rtl/traffic_pkg.sv
// Shared definitions for the intersection controller and its timed helpers.
package traffic_pkg;

  // Per-approach lamp code driven onto the lamp drivers.
  typedef enum logic [1:0] {
    LT_RED    = 2'b00,
    LT_GREEN  = 2'b01,
    LT_YELLOW = 2'b10,
    LT_DARK   = 2'b11
  } light_t;

  typedef enum logic [1:0] {
    ST_GREEN  = 2'b00,
    ST_YELLOW = 2'b01,
    ST_ALLRED = 2'b10,
    ST_FLASH  = 2'b11
  } state_t;

  // Operator mode select; the first three pick a cycle class.
  typedef enum logic [1:0] {
    MODE_30    = 2'b00,
    MODE_60    = 2'b01,
    MODE_90    = 2'b10,
    MODE_FLASH = 2'b11
  } mode_t;

  // Green time is the cycle class minus the yellow interval.
  localparam int GREEN_T_30 = 25;
  localparam int GREEN_T_60 = 55;
  localparam int GREEN_T_90 = 85;

  // Green seconds for a mode; flash never loads a green, so it returns 0.
  function automatic int green_secs(input logic [1:0] mode);
    case (mode)
      MODE_30: return GREEN_T_30;
      MODE_60: return GREEN_T_60;
      MODE_90: return GREEN_T_90;
      default: return 0;
    endcase
  endfunction

endpackage

// File: rtl/traffic_phase_ctrl_if.sv
// Control/status bundle between the intersection controller and its environment.
// master: the side that supplies mode and pedestrian buttons and reads lamps.
// slave:  the controller itself.
interface traffic_phase_ctrl_if #(
  parameter int NUM_DIR = 2,
  parameter int CNT_W   = 7
);
  localparam int DIR_W = $clog2(NUM_DIR);

  logic [1:0]           mode;
  logic [NUM_DIR-1:0]   ped_req;
  logic [2*NUM_DIR-1:0] light_out;
  logic [NUM_DIR-1:0]   ped_walk;
  logic [DIR_W-1:0]     active_dir;
  logic [CNT_W-1:0]     remaining;

  modport master (
    output mode,
    output ped_req,
    input  light_out,
    input  ped_walk,
    input  active_dir,
    input  remaining
  );

  modport slave (
    input  mode,
    input  ped_req,
    output light_out,
    output ped_walk,
    output active_dir,
    output remaining
  );

endinterface

// File: rtl/traffic_phase_ctrl_sec_tick_gen.sv
// Seconds prescaler: one-cycle tick every TICK_DIV clocks, first tick
// consumed TICK_DIV edges after reset release.
module sec_tick_gen #(
  parameter int TICK_DIV = 50_000_000
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);
  localparam int                DIV_W    = $clog2(TICK_DIV);
  localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(TICK_DIV - 1);

  logic [DIV_W-1:0] div_q;
  logic [DIV_W-1:0] div_d;

  // Tick decodes the registered count, so it is a clean single-cycle strobe.
  assign tick = (div_q == DIV_LAST);

  // Wrap to zero on the tick cycle, otherwise count up.
  always_comb begin
    div_d = tick ? '0 : div_q + 1'b1;
  end

  // Prescaler register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) div_q <= '0;
    else        div_q <= div_d;
  end

endmodule

// File: rtl/traffic_phase_ctrl.sv
// N-approach intersection controller: round-robin green/yellow/all-red with
// latched pedestrian walks and a flashing-yellow night mode.
//
//   state     | meaning
//   ----------+--------------------------------------------------------
//   ST_GREEN  | approach dir_q green, others red; walk lamp if served
//   ST_YELLOW | approach dir_q yellow, others red
//   ST_ALLRED | every approach red; decides flash vs next green
//   ST_FLASH  | every approach alternates yellow/dark each tick
module traffic_phase_ctrl
  import traffic_pkg::*;
#(
  parameter int NUM_DIR   = 2,
  parameter int CNT_W     = 7,
  parameter int TICK_DIV  = 50_000_000,
  parameter int YELLOW_T  = 5,
  parameter int ALLRED_T  = 2,
  parameter int PED_MIN_T = 40
) (
  input logic                 clk,
  input logic                 rst_n,
  traffic_phase_ctrl_if.slave bus
);
  localparam int               DIR_W   = $clog2(NUM_DIR);
  localparam logic [CNT_W-1:0] YEL_LD  = CNT_W'(YELLOW_T - 1);
  localparam logic [CNT_W-1:0] AR_LD   = CNT_W'(ALLRED_T - 1);
  localparam logic [DIR_W-1:0] DIR_MAX = DIR_W'(NUM_DIR - 1);

  logic                 tick;

  state_t               state_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [DIR_W-1:0]     dir_q;
  logic [2*NUM_DIR-1:0] light_q;
  logic [NUM_DIR-1:0]   walk_q;
  logic [NUM_DIR-1:0]   pend_q;
  logic [NUM_DIR-1:0]   pend_d;

  logic [DIR_W-1:0]     next_dir;
  logic                 green_walk;
  int                   green_secs_c;
  logic [CNT_W-1:0]     green_ld;
  logic                 enter_green;
  logic [NUM_DIR-1:0]   pend_clr;

  // Lamp vector with a single approach showing code, all others red.
  function automatic logic [2*NUM_DIR-1:0] lamp_one(input logic [DIR_W-1:0] d,
                                                    input light_t code);
    logic [2*NUM_DIR-1:0] v;
    v = '0;
    for (int i = 0; i < NUM_DIR; i++) begin
      if (d == DIR_W'(i)) v[2*i +: 2] = code;
    end
    return v;
  endfunction

  function automatic logic [NUM_DIR-1:0] dir_onehot(input logic [DIR_W-1:0] d);
    logic [NUM_DIR-1:0] v;
    v = '0;
    for (int i = 0; i < NUM_DIR; i++) begin
      if (d == DIR_W'(i)) v[i] = 1'b1;
    end
    return v;
  endfunction

  sec_tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_sec_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .tick  (tick)
  );

  // Next green's approach, duration and walk decision, plus the pedestrian
  // latch update. Clear wins over the old pending bit, but a press in the
  // same cycle re-arms it for the following rotation.
  always_comb begin
    next_dir     = (dir_q == DIR_MAX) ? '0 : dir_q + 1'b1;
    green_walk   = pend_q[next_dir];
    green_secs_c = green_secs(bus.mode);
    if (green_walk && (green_secs_c < PED_MIN_T)) green_secs_c = PED_MIN_T;
    green_ld     = CNT_W'(green_secs_c - 1);
    enter_green  = tick && (state_q == ST_ALLRED) && (cnt_q == '0) &&
                   (bus.mode != MODE_FLASH);
    pend_clr     = enter_green ? dir_onehot(next_dir) : '0;
    pend_d       = (pend_q & ~pend_clr) | bus.ped_req;
  end

  // Phase sequencer with the inline interval down-counter and registered lamps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_ALLRED;
      cnt_q   <= AR_LD;
      dir_q   <= DIR_MAX;
      light_q <= '0;
      walk_q  <= '0;
      pend_q  <= '0;
    end else begin
      pend_q <= pend_d;
      if (tick) begin
        if (state_q == ST_FLASH) begin
          // Flash holds the counter at zero and leaves on the first tick
          // that sees a non-flash mode.
          if (bus.mode != MODE_FLASH) begin
            state_q <= ST_ALLRED;
            cnt_q   <= AR_LD;
            light_q <= '0;
          end else if (light_q[1:0] == LT_YELLOW) begin
            light_q <= {NUM_DIR{LT_DARK}};
          end else begin
            light_q <= {NUM_DIR{LT_YELLOW}};
          end
        end else if (cnt_q != '0) begin
          cnt_q <= cnt_q - 1'b1;
        end else if (state_q == ST_GREEN) begin
          state_q <= ST_YELLOW;
          cnt_q   <= YEL_LD;
          light_q <= lamp_one(dir_q, LT_YELLOW);
          walk_q  <= '0;
        end else if (state_q == ST_YELLOW) begin
          state_q <= ST_ALLRED;
          cnt_q   <= AR_LD;
          light_q <= '0;
        end else if (bus.mode == MODE_FLASH) begin
          // Night mode is only honoured here, so a running green or yellow
          // always completes before the intersection starts flashing.
          state_q <= ST_FLASH;
          cnt_q   <= '0;
          light_q <= {NUM_DIR{LT_YELLOW}};
        end else begin
          state_q <= ST_GREEN;
          dir_q   <= next_dir;
          cnt_q   <= green_ld;
          light_q <= lamp_one(next_dir, LT_GREEN);
          walk_q  <= green_walk ? dir_onehot(next_dir) : '0;
        end
      end
    end
  end

  assign bus.light_out  = light_q;
  assign bus.ped_walk   = walk_q;
  assign bus.active_dir = dir_q;
  assign bus.remaining  = cnt_q;

endmodule

// File: doc/traffic_phase_ctrl.md
Name: traffic_phase_ctrl

Overview:
Parametrised N-approach intersection controller and successor to the 2-bit single-light controller. It cycles green, yellow and all-red clearance across NUM_DIR approaches, with mode-selected green times. It adds latched pedestrian requests with walk outputs, a flashing-yellow night mode, and a built-in seconds prescaler. It sits at top level and drives the lamp drivers directly; remaining time goes to the countdown display.

Parameters:
NUM_DIR, 2, number of approaches served round-robin (2..4).
CNT_W, 7, interval counter width; all durations must be < 2^CNT_W.
TICK_DIV, 50_000_000, clk cycles per 1 s tick (>= 2).
YELLOW_T, 5, yellow duration in seconds.
ALLRED_T, 2, all-red clearance in seconds.
PED_MIN_T, 40, minimum green in seconds when a walk is served.

Ports:
clk  in  1  system clock.
rst_n  in  1  asynchronous, active-low reset.
mode  in  2  00: 30 s, 01: 60 s, 10: 90 s cycle class (green = class - 5); 11: flash.
ped_req  in  NUM_DIR  per-approach pedestrian button, level or pulse, 1 cycle minimum.
light_out  out  2*NUM_DIR  per-approach code, dir d in bits [2d+1:2d]: 00 red, 01 green, 10 yellow, 11 dark.
ped_walk  out  NUM_DIR  walk lamp, one bit per approach.
active_dir  out  $clog2(NUM_DIR)  approach currently or last served.
remaining  out  CNT_W  seconds left in the current interval, minus 1.

Behaviour:
- Tick generation: prescaler counts 0..TICK_DIV-1. tick is asserted for 1 cycle when the count wraps. The first tick after reset comes TICK_DIV cycles later.
- Interval counter: load T-1 on interval entry; decrement on tick while nonzero. On a tick with count==0, the interval ends and state/lights change on the next clk edge. An interval of T lasts exactly T ticks.
- States: GREEN, YELLOW, ALLRED, FLASH.
- GREEN (dir = active_dir):
  - light[dir]=01, all others 00.
  - Duration is G = 25/55/85 per mode, sampled at entry.
  - If ped_pend[dir] is set at entry: G = max(G, PED_MIN_T); ped_walk[dir]=1 for the whole green; ped_pend[dir] is cleared at entry.
  - Next state: YELLOW.
- YELLOW: light[dir]=10; duration YELLOW_T; ped_walk all 0; next state ALLRED.
- ALLRED:
  - All lights 00; duration ALLRED_T.
  - At end, if mode==11, go to FLASH.
  - Otherwise active_dir <= (active_dir+1) mod NUM_DIR and go to GREEN.
- FLASH:
  - All approaches alternate 10 and 11, toggling every tick, starting with 10.
  - ped_walk all 0; remaining held at 0.
  - On the first tick with mode!=11, enter ALLRED with ALLRED_T; the next green is active_dir+1.
- Mode change rules:
  - A change among 00/01/10 affects only the next green load.
  - mode==11 never truncates GREEN or YELLOW; it is honoured only at the end of ALLRED.
- Pedestrian latch: ped_pend[d] sets on ped_req[d]. A request arriving during dir d's own green sets pending and is served next rotation. A set and a clear in the same cycle resolve to clear, then re-set from ped_req.
- Reset values:
  - state ALLRED, count ALLRED_T-1, active_dir NUM_DIR-1 (so the first green is dir 0).
  - light_out all 00, ped_walk 0, ped_pend 0, prescaler 0.
- Reset mid-operation returns to these values immediately (asynchronous assertion); release is synchronised by the system.
- Invariant: at most one approach is non-red outside FLASH. The bench asserts this.

Decomposition:
- Shared package traffic_pkg holds:
  - light codes LT_RED/LT_GREEN/LT_YELLOW/LT_DARK;
  - state enum;
  - mode codes;
  - green-time constants 25/55/85.
- One sub-module, sec_tick_gen (parameter TICK_DIV; ports clk, rst_n, tick), is reused by other timed blocks.
- The interval counter stays inline.

Test Plan:
1. Reset with TICK_DIV=4, NUM_DIR=2, mode=00:
   - lights all red for 2 ticks (8 cycles);
   - then dir0 green for 25 ticks, with remaining counting 24..0;
   - then yellow for 5 ticks, all-red for 2 ticks, then dir1 green.
2. Pulse ped_req[1] for 1 cycle during dir0 green, mode=00 -> dir1 green lasts 40 ticks, ped_walk[1]=1 throughout, ped_pend[1] cleared; the next dir1 green returns to 25 ticks.
3. Switch mode 00->10 mid-green of dir0 -> current green still ends at 25 ticks; the next green (dir1) lasts 85 ticks.
4. Set mode=11 during dir0 green -> green completes, then yellow 5 and all-red 2, then FLASH. Both approaches toggle 10/11 each tick. Return mode=00 -> all-red 2 ticks, then dir1 green.
5. Assert rst_n low mid-yellow -> outputs go to reset values in the same cycle; after release the sequence restarts as in scenario 1.
6. NUM_DIR=4 with random ped_req over 3 full rotations -> order 0,1,2,3,0...; never two approaches non-red; each request is served exactly once with a walk.
